// File: rtl/sum_accum_engine_if.sv
// sum_accum_engine_if
// Bus between the system controller and the summing engine: operation
// control (start/mode), the input word with its valid/ready handshake,
// and the status/result returned by the engine.
// The controller side uses the master modport; the engine uses the slave modport.

interface sum_accum_engine_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);

    logic             start;
    logic             mode;
    logic [IN_W-1:0]  in_bus;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] sum_out;
    logic             overflow;

    // The controller drives requests and stream words, then observes status and result.
    modport master (
        output start,
        output mode,
        output in_bus,
        output in_valid,
        input  in_ready,
        input  busy,
        input  done,
        input  sum_out,
        input  overflow
    );

    // The engine samples requests and stream words, then drives status and result.
    modport slave (
        input  start,
        input  mode,
        input  in_bus,
        input  in_valid,
        output in_ready,
        output busy,
        output done,
        output sum_out,
        output overflow
    );

endinterface

// File: rtl/sum_accum_engine.sv
// sum_accum_engine
// Multi-mode summing engine with controller and datapath in one block.
//   SERIES mode: computes 1+2+...+N, where N is taken from in_bus at start.
//   STREAM mode: accumulates N words accepted over the in_valid/in_ready handshake.
// The state sequence is IDLE -> RUN -> DONE -> IDLE. done is high for the single
// DONE cycle. sum_out and overflow hold their values until the next accepted start.
// Each add is computed one bit wider than the accumulator. The carry out of that
// add sets the sticky overflow flag for the current operation.
// Build option:
//   SUM_SAT_EN defined   - on a carry the accumulator saturates to all ones and
//                          stays there for the rest of the operation.
//   SUM_SAT_EN undefined - the accumulator wraps modulo 2^OUT_W.
// In both builds overflow is reported the same way.

module sum_accum_engine #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    sum_accum_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        SERIES = 1'b0,
        STREAM = 1'b1
    } mode_t;

    state_t            r_state;
    state_t            w_nextState;

    mode_t             r_mode;
    logic [IN_W-1:0]   r_n;
    logic [IN_W-1:0]   r_count;
    logic [OUT_W-1:0]  r_acc;
    logic              r_overflow;

    logic              w_startAccepted;
    logic              w_nIsZero;
    logic              w_addEn;
    logic              w_lastAdd;
    logic [IN_W-1:0]   w_countInc;
    logic [OUT_W-1:0]  w_addend;
    logic [OUT_W:0]    w_sumWide;
    logic              w_carry;
    logic [OUT_W-1:0]  w_accNext;
    logic              w_inReady;
    logic              w_busy;
    logic              w_done;

    // A start request counts only in IDLE. A start seen in RUN or DONE is
    // ignored and has to be seen again once the engine is back in IDLE.
    assign w_startAccepted = (r_state == IDLE) && bus.start;
    assign w_nIsZero       = (bus.in_bus == '0);

    // In SERIES mode the engine adds on every RUN cycle. In STREAM mode it
    // adds only when a word is handed over. in_ready is high for all of RUN,
    // so in_valid alone decides whether a transfer happens.
    assign w_addEn    = (r_state == RUN) && ((r_mode == SERIES) || bus.in_valid);
    assign w_countInc = r_count + IN_W'(1);

    // SERIES counts 1..N and finishes on the add where count equals N.
    // STREAM counts accepted words from zero and finishes on the Nth word.
    assign w_lastAdd = (r_mode == SERIES) ? (r_count == r_n) : (w_countInc == r_n);

    // The addend is either the running count or the stream word, zero-extended.
    // The sum is one bit wider so that the carry can be captured for overflow.
    assign w_addend  = (r_mode == SERIES) ? OUT_W'(r_count) : OUT_W'(bus.in_bus);
    assign w_sumWide = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_carry   = w_sumWide[OUT_W];

`ifdef SUM_SAT_EN
    // Saturating build: any carry pins the accumulator at all ones. A
    // saturated accumulator carries again on any non-zero add, and adding
    // zero leaves it unchanged, so it stays pinned for the rest of the operation.
    assign w_accNext = w_carry ? {OUT_W{1'b1}} : w_sumWide[OUT_W-1:0];
`else
    // Wrapping build: the carry is dropped and the accumulator wraps modulo 2^OUT_W.
    assign w_accNext = w_sumWide[OUT_W-1:0];
`endif

    // State register. Reset returns to IDLE immediately, which abandons any
    // operation in progress without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and status outputs. N == 0 skips RUN and goes straight
    // to DONE, so done still pulses once with a zero result.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startAccepted) begin
                    w_nextState = w_nIsZero ? DONE : RUN;
                end
            end
            RUN: begin
                w_busy    = 1'b1;
                w_inReady = (r_mode == STREAM);
                if (w_addEn && w_lastAdd) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. An accepted start loads N and mode, clears the
    // accumulator and the overflow flag, and sets the counter's start value.
    // Each add updates the accumulator, the sticky overflow flag and the
    // counter. Outside these events the registers hold, which keeps the
    // result stable through DONE and IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode     <= SERIES;
            r_n        <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (w_startAccepted) begin
            r_mode     <= mode_t'(bus.mode);
            r_n        <= bus.in_bus;
            r_count    <= bus.mode ? '0 : IN_W'(1);
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else if (w_addEn) begin
            r_acc      <= w_accNext;
            r_overflow <= r_overflow | w_carry;
            r_count    <= w_countInc;
        end
    end

    assign bus.in_ready = w_inReady;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sum_out  = r_acc;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_sum_accum_engine.sv
// tb_sum_accum_engine
// Directed bench for sum_accum_engine with hand-computed expected values.
// dutA uses the default widths (IN_W=8, OUT_W=16). dutB uses OUT_W=12 to
// exercise the overflow path. The expected result for dutB depends on
// whether SUM_SAT_EN is defined.

module tb_sum_accum_engine;

    logic clk;
    logic rst;

    int compareCount;
    int mismatchCount;
    int doneCountA;
    int doubleDoneA;
    int handshakeA;
    logic prevDoneA;

    sum_accum_engine_if #(.IN_W(8), .OUT_W(16)) ifA ();
    sum_accum_engine_if #(.IN_W(8), .OUT_W(12)) ifB ();

    sum_accum_engine #(.IN_W(8), .OUT_W(16)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    sum_accum_engine #(.IN_W(8), .OUT_W(12)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Track done pulses on dutA and flag any done that is high on two
    // consecutive cycles. Sampled on the falling edge, away from the active edge.
    initial begin
        doneCountA  = 0;
        doubleDoneA = 0;
        prevDoneA   = 1'b0;
        forever begin
            @(negedge clk);
            if (ifA.done === 1'b1) begin
                doneCountA++;
                if (prevDoneA === 1'b1) doubleDoneA++;
            end
            prevDoneA = ifA.done;
        end
    end

    // Count stream handshakes accepted by dutA at each rising edge.
    initial begin
        handshakeA = 0;
        forever begin
            @(posedge clk);
            if (ifA.in_valid === 1'b1 && ifA.in_ready === 1'b1) handshakeA++;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue a start on dutA. The start is driven on a falling edge and
    // withdrawn just after the rising edge that samples it.
    task automatic applyStimulus(input logic modeBit, input logic [7:0] n);
        @(negedge clk);
        ifA.start  = 1'b1;
        ifA.mode   = modeBit;
        ifA.in_bus = n;
        @(posedge clk);
        #1;
        ifA.start  = 1'b0;
        ifA.in_bus = 8'h00;
    endtask

    // Count falling edges until dutA raises done, up to a fixed limit.
    task automatic waitDoneA(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (ifA.done === 1'b1) break;
        end
        checkOutput("doneSeenA", {31'b0, ifA.done}, 32'd1);
    endtask

    int cycles;
    logic [7:0] words [3];
    int hsBase;
    logic [11:0] expB;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        words[0] = 8'h05;
        words[1] = 8'hFF;
        words[2] = 8'h07;

        rst          = 1'b0;
        ifA.start    = 1'b0;
        ifA.mode     = 1'b0;
        ifA.in_bus   = 8'h00;
        ifA.in_valid = 1'b0;
        ifB.start    = 1'b0;
        ifB.mode     = 1'b0;
        ifB.in_bus   = 8'h00;
        ifB.in_valid = 1'b0;

        // Outputs while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rstSum",     {16'b0, ifA.sum_out}, 32'd0);
        checkOutput("rstBusy",    {31'b0, ifA.busy},     32'd0);
        checkOutput("rstDone",    {31'b0, ifA.done},     32'd0);
        checkOutput("rstReady",   {31'b0, ifA.in_ready}, 32'd0);
        checkOutput("rstOvf",     {31'b0, ifA.overflow}, 32'd0);
        rst = 1'b1;

        // SERIES with N=16: done appears 17 cycles after the start edge, sum 136.
        applyStimulus(1'b0, 8'd16);
        waitDoneA(100, cycles);
        checkOutput("ser16Latency", cycles,               32'd17);
        checkOutput("ser16Sum",     {16'b0, ifA.sum_out}, 32'd136);
        checkOutput("ser16Ovf",     {31'b0, ifA.overflow}, 32'd0);
        checkOutput("ser16BusyDone",{31'b0, ifA.busy},    32'd1);
        @(negedge clk);
        checkOutput("ser16IdleBusy",{31'b0, ifA.busy},    32'd0);
        checkOutput("ser16Hold",    {16'b0, ifA.sum_out}, 32'd136);

        // STREAM with N=3: words 5, 0xFF, 7 with two-cycle gaps. 5+255+7 = 267.
        hsBase = handshakeA;
        applyStimulus(1'b1, 8'd3);
        for (int w = 0; w < 3; w++) begin
            repeat (2) @(negedge clk);
            @(negedge clk);
            checkOutput("strReady", {31'b0, ifA.in_ready}, 32'd1);
            if (w == 2) checkOutput("strLive", {16'b0, ifA.sum_out}, 32'd260);
            ifA.in_valid = 1'b1;
            ifA.in_bus   = words[w];
            @(posedge clk);
            #1;
            if (w < 2) ifA.in_valid = 1'b0;
        end
        ifA.in_bus = 8'h55;
        @(negedge clk);
        checkOutput("strDone",   {31'b0, ifA.done},     32'd1);
        checkOutput("strReadyLo",{31'b0, ifA.in_ready}, 32'd0);
        checkOutput("strSum",    {16'b0, ifA.sum_out},  32'd267);
        checkOutput("strHs",     handshakeA - hsBase,   32'd3);
        repeat (3) @(negedge clk);
        checkOutput("strHsAfter",  handshakeA - hsBase,  32'd3);
        checkOutput("strSumAfter", {16'b0, ifA.sum_out}, 32'd267);
        checkOutput("strIdle",     {31'b0, ifA.busy},    32'd0);
        ifA.in_valid = 1'b0;
        ifA.in_bus   = 8'h00;

        // N=0 in both modes: done the cycle after start, zero result, idle a cycle later.
        for (int m = 0; m < 2; m++) begin
            applyStimulus(m[0], 8'd0);
            @(negedge clk);
            checkOutput("zeroDone", {31'b0, ifA.done},    32'd1);
            checkOutput("zeroSum",  {16'b0, ifA.sum_out}, 32'd0);
            checkOutput("zeroBusy", {31'b0, ifA.busy},    32'd1);
            @(negedge clk);
            checkOutput("zeroIdle",   {31'b0, ifA.busy}, 32'd0);
            checkOutput("zeroDoneLo", {31'b0, ifA.done}, 32'd0);
        end

        // OUT_W=12, SERIES, N=255: the true sum 32640 wraps to 0xF80 or saturates to 0xFFF.
`ifdef SUM_SAT_EN
        expB = 12'hFFF;
`else
        expB = 12'hF80;
`endif
        @(negedge clk);
        ifB.start  = 1'b1;
        ifB.mode   = 1'b0;
        ifB.in_bus = 8'd255;
        @(posedge clk);
        #1;
        ifB.start  = 1'b0;
        ifB.in_bus = 8'h00;
        cycles = 0;
        while (cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (ifB.done === 1'b1) break;
        end
        checkOutput("w12Latency", cycles,               32'd256);
        checkOutput("w12Sum",     {20'b0, ifB.sum_out}, {20'b0, expB});
        checkOutput("w12Ovf",     {31'b0, ifB.overflow}, 32'd1);

        // Reset mid-RUN for SERIES N=200. After 49 adds the live sum is 1225.
        applyStimulus(1'b0, 8'd200);
        repeat (50) @(negedge clk);
        checkOutput("abortLive", {16'b0, ifA.sum_out}, 32'd1225);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortSum",  {16'b0, ifA.sum_out}, 32'd0);
        checkOutput("abortBusy", {31'b0, ifA.busy},    32'd0);
        checkOutput("abortDone", {31'b0, ifA.done},    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortIdle", {31'b0, ifA.busy}, 32'd0);
        applyStimulus(1'b0, 8'd4);
        waitDoneA(50, cycles);
        checkOutput("n4Latency", cycles,               32'd5);
        checkOutput("n4Sum",     {16'b0, ifA.sum_out}, 32'd10);

        // start held high through RUN and DONE of an N=5 op: one result of 15,
        // then a fresh operation that starts from IDLE.
        @(negedge clk);
        ifA.start  = 1'b1;
        ifA.mode   = 1'b0;
        ifA.in_bus = 8'd5;
        waitDoneA(50, cycles);
        checkOutput("held1Latency", cycles,               32'd6);
        checkOutput("held1Sum",     {16'b0, ifA.sum_out}, 32'd15);
        @(negedge clk);
        checkOutput("heldIdle",   {31'b0, ifA.busy},    32'd0);
        checkOutput("heldHold",   {16'b0, ifA.sum_out}, 32'd15);
        @(posedge clk);
        #1;
        ifA.start  = 1'b0;
        ifA.in_bus = 8'h00;
        waitDoneA(50, cycles);
        checkOutput("held2Latency", cycles,               32'd6);
        checkOutput("held2Sum",     {16'b0, ifA.sum_out}, 32'd15);
        repeat (3) @(negedge clk);

        checkOutput("doneDouble", doubleDoneA, 32'd0);
        checkOutput("donePulses", doneCountA,  32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
